// File: rtl/mac_out_requant.sv
// Requantizes 18-bit MAC results (bias, round, shift, ReLU, saturate to int8) into an indexed FWFT FIFO.
// Latency 2 cycles from input acceptance to FIFO write; no back-pressure upstream, so results are dropped while the FIFO is full.
module mac_out_requant #(
    parameter int FIFO_DEPTH = 4,
    parameter int IDX_W      = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic                            clear,
    input  logic                            in_valid,
    input  logic signed [17:0]              in_data,
    input  logic signed [17:0]              bias,
    input  logic        [3:0]               shift,
    input  logic                            relu_en,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic signed [7:0]               out_data,
    output logic        [IDX_W-1:0]         out_idx,
    output logic                            sat_flag,
    output logic                            ovf_flag,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int              PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int              LW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LW-1:0]   DEPTH_L = LW'(FIFO_DEPTH);

    logic                    w_accept;
    logic                    r_s1_vld;
    logic signed [18:0]      r_s1_sum;
    logic        [3:0]       r_s1_shift;
    logic                    r_s1_relu;

    logic signed [19:0]      w_ext;
    logic signed [19:0]      w_half;
    logic signed [19:0]      w_rnd;
    logic signed [19:0]      w_r;
    logic signed [7:0]       w_q;
    logic                    w_sat;

    logic                    r_s2_vld;
    logic signed [7:0]       r_s2_dat;

    logic signed [7:0]       r_mem_dat [FIFO_DEPTH];
    logic        [IDX_W-1:0] r_mem_idx [FIFO_DEPTH];
    logic        [PW-1:0]    r_wr_ptr;
    logic        [PW-1:0]    r_rd_ptr;
    logic        [LW-1:0]    r_level;
    logic        [IDX_W-1:0] r_idx;
    logic                    r_sat;
    logic                    r_ovf;

    logic                    w_pop;
    logic                    w_push;
    logic                    w_drop;

    assign w_accept = en && in_valid;

    // Stage 1: bias add at 19 bits so no overflow is possible.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_s1_vld <= 1'b0;
        end else begin
            r_s1_vld <= w_accept;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_sum   <= {in_data[17], in_data} + {bias[17], bias};
            r_s1_shift <= shift;
            r_s1_relu  <= relu_en;
        end
    end

    // Half-LSB offset before the arithmetic shift gives round-half-up toward +inf.
    always_comb begin
        w_ext  = {r_s1_sum[18], r_s1_sum};
        w_half = (r_s1_shift == 4'd0) ? 20'sd0 : (20'sd1 <<< (r_s1_shift - 4'd1));
        w_rnd  = w_ext + w_half;
        w_r    = w_rnd >>> r_s1_shift;
        w_q    = w_r[7:0];
        w_sat  = 1'b0;
        if (r_s1_relu && w_r[19]) begin
            w_q = 8'sd0;
        end else if (w_r > 20'sd127) begin
            w_q   = 8'sd127;
            w_sat = 1'b1;
        end else if (w_r < -20'sd128) begin
            w_q   = -8'sd128;
            w_sat = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_s2_vld <= 1'b0;
            r_sat    <= 1'b0;
        end else begin
            r_s2_vld <= r_s1_vld;
            r_sat    <= r_sat | (r_s1_vld & w_sat);
        end
    end

    always_ff @(posedge clk) begin
        if (r_s1_vld) begin
            r_s2_dat <= w_q;
        end
    end

    // A pop frees the slot in the same cycle, so push-at-full succeeds when the head leaves.
    assign w_pop  = (r_level != '0) && out_ready;
    assign w_push = r_s2_vld && ((r_level != DEPTH_L) || w_pop);
    assign w_drop = r_s2_vld && !w_push;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_idx    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_push);
            r_rd_ptr <= r_rd_ptr + PW'(w_pop);
            r_level  <= r_level + LW'(w_push) - LW'(w_pop);
            r_idx    <= r_idx + IDX_W'(w_push);
            r_ovf    <= r_ovf | w_drop;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_dat[r_wr_ptr] <= r_s2_dat;
            r_mem_idx[r_wr_ptr] <= r_idx;
        end
    end

    assign out_valid  = (r_level != '0);
    assign out_data   = out_valid ? r_mem_dat[r_rd_ptr] : 8'sd0;
    assign out_idx    = out_valid ? r_mem_idx[r_rd_ptr] : '0;
    assign sat_flag   = r_sat;
    assign ovf_flag   = r_ovf;
    assign fifo_level = r_level;

endmodule

// File: tb/tb_mac_out_requant.sv
// Directed and randomized checks of mac_out_requant against a transaction-level model.
// The model keeps in-flight results as timestamped items and the FIFO as a queue.
module tb_mac_out_requant;

    localparam int D = 4;

    logic               clk = 1'b0;
    logic               rst_n, en, clear, in_valid, relu_en, out_ready;
    logic signed [17:0] in_data, bias;
    logic        [3:0]  shift;
    logic               out_valid, sat_flag, ovf_flag;
    logic signed [7:0]  out_data;
    logic        [7:0]  out_idx;
    logic        [2:0]  fifo_level;

    int checks = 0;
    int errors = 0;

    typedef struct { int res; bit sat; int due; } fl_t;
    typedef struct { int res; int idx; } fe_t;

    fl_t pipe[$];
    fe_t fifo[$];
    int  cyc   = 0;
    int  m_idx = 0;
    bit  m_sat = 0;
    bit  m_ovf = 0;

    always #5 clk = ~clk;

    mac_out_requant #(.FIFO_DEPTH(D), .IDX_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .bias(bias), .shift(shift), .relu_en(relu_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .sat_flag(sat_flag), .ovf_flag(ovf_flag), .fifo_level(fifo_level)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Requantization rule in plain integer arithmetic (floor division for the shift).
    function automatic void ref_q(input int d, input int b, input int sh, input bit relu,
                                  output int q, output bit s);
        int sum, r, m, md;
        sum = d + b;
        s   = 1'b0;
        if (sh == 0) begin
            r = sum;
        end else begin
            m  = 1 << sh;
            r  = sum + m / 2;
            md = ((r % m) + m) % m;
            r  = (r - md) / m;
        end
        if (relu && r < 0) q = 0;
        else if (r > 127) begin q = 127; s = 1'b1; end
        else if (r < -128) begin q = -128; s = 1'b1; end
        else q = r;
    endfunction

    task automatic tick();
        bit  pop, full, s;
        int  q;
        fl_t p;
        @(posedge clk);
        cyc++;
        if (!rst_n || clear) begin
            pipe.delete();
            fifo.delete();
            m_idx = 0;
            m_sat = 1'b0;
            m_ovf = 1'b0;
        end else begin
            pop  = (fifo.size() > 0) && out_ready;
            full = (fifo.size() >= D);
            if (pop) void'(fifo.pop_front());
            if (pipe.size() > 0 && pipe[0].due == cyc) begin
                p = pipe.pop_front();
                if (!full || pop) begin
                    fifo.push_back('{res: p.res, idx: m_idx});
                    m_idx = (m_idx + 1) % 256;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            foreach (pipe[i]) if (pipe[i].due == cyc + 1 && pipe[i].sat) m_sat = 1'b1;
            if (en && in_valid) begin
                ref_q(int'(in_data), int'(bias), int'(shift), relu_en, q, s);
                pipe.push_back('{res: q, sat: s, due: cyc + 2});
            end
        end
        #1;
        check("out_valid", out_valid, fifo.size() > 0);
        if (fifo.size() > 0) begin
            check("out_data", out_data, fifo[0].res);
            check("out_idx", out_idx, fifo[0].idx);
        end
        check("fifo_level", fifo_level, fifo.size());
        check("sat_flag", sat_flag, m_sat);
        check("ovf_flag", ovf_flag, m_ovf);
    endtask

    task automatic drive(input bit v, input int d, input int b, input int sh, input bit relu);
        in_valid = v;
        in_data  = 18'(d);
        bias     = 18'(b);
        shift    = 4'(sh);
        relu_en  = relu;
    endtask

    task automatic drive_rand();
        drive(1'b1, $signed(18'($urandom)), $signed(18'($urandom_range(0, 4095))) - 2048,
              $urandom_range(0, 15), 1'($urandom));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; clear = 1'b0; en = 1'b1;
        drive(1'b0, 0, 0, 0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        out_ready = 1'b1;
        do_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_sat", sat_flag, 0);
        check("rst_ovf", ovf_flag, 0);
        check("rst_level", fifo_level, 0);

        // Basic rounding example.
        drive(1'b1, 300, -44, 2, 1'b0);
        tick();
        drive(1'b0, 0, 0, 0, 1'b0);
        tick();
        check("ex1_valid_early", out_valid, 0);
        tick();
        check("ex1_valid", out_valid, 1);
        check("ex1_data", out_data, 64);
        check("ex1_idx", out_idx, 0);
        check("ex1_sat", sat_flag, 0);
        tick();

        // Negative saturation, then the same value under ReLU.
        do_reset();
        drive(1'b1, -1000, 0, 1, 1'b0);
        tick();
        drive(1'b0, 0, 0, 0, 1'b0);
        tick();
        tick();
        check("sat_data", out_data, -128);
        check("sat_flag", sat_flag, 1);
        do_reset();
        drive(1'b1, -1000, 0, 1, 1'b1);
        tick();
        drive(1'b0, 0, 0, 0, 1'b0);
        tick();
        tick();
        check("relu_data", out_data, 0);
        check("relu_sat", sat_flag, 0);

        // Overflow: six inputs into a stalled four-entry FIFO.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin drive_rand(); tick(); end
        drive(1'b0, 0, 0, 0, 1'b0);
        tick();
        tick();
        check("ovf_level", fifo_level, 4);
        check("ovf_flag", ovf_flag, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("ovf_drain_idx", out_idx, i);
            tick();
        end
        check("ovf_drain_level", fifo_level, 0);

        // Full FIFO with simultaneous push and pop.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 26; i++) begin
            out_ready = (i >= 6);
            drive_rand();
            tick();
            if (i >= 5) check("full_level", fifo_level, 4);
        end
        check("full_ovf", ovf_flag, 0);

        // Index counter wrap.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 257; i++) begin drive_rand(); tick(); end
        drive(1'b0, 0, 0, 0, 1'b0);
        tick();
        tick();
        check("wrap_valid", out_valid, 1);
        check("wrap_idx", out_idx, 0);

        // Randomized traffic with occasional clears and enable gaps.
        do_reset();
        for (int i = 0; i < 500; i++) begin
            en        = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 39) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            drive_rand();
            in_valid  = ($urandom_range(0, 3) != 0);
            tick();
        end
        clear = 1'b0;
        en    = 1'b1;

        // Flush with buffered and in-flight data: once by clear, once by reset.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            out_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin drive(1'b1, 100000, 0, 0, 1'b0); tick(); end
            check("flush_pre_level", fifo_level, 3);
            check("flush_pre_sat", sat_flag, 1);
            if (pass == 0) clear = 1'b1; else rst_n = 1'b0;
            tick();
            clear = 1'b0;
            rst_n = 1'b1;
            check("flush_valid", out_valid, 0);
            check("flush_level", fifo_level, 0);
            check("flush_sat", sat_flag, 0);
            check("flush_ovf", ovf_flag, 0);
            drive(1'b0, 0, 0, 0, 1'b0);
            tick();
            tick();
            check("flush_inflight_level", fifo_level, 0);
            out_ready = 1'b1;
            drive(1'b1, 50, 7, 0, 1'b0);
            tick();
            drive(1'b0, 0, 0, 0, 1'b0);
            tick();
            tick();
            check("flush_next_valid", out_valid, 1);
            check("flush_next_idx", out_idx, 0);
            check("flush_next_data", out_data, 57);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
